// File: rtl/proc_pkg.sv
// Shared processor types for the data-memory path: widths, port identities
// and the per-port access request bundle.
package proc_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned DMEM_ADDR_W    = 10;
    localparam int unsigned NUM_DMEM_PORTS = 2;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } dmem_port_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]      wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side bus of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic [1:0]             req;
    logic [1:0]             we;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata;
    logic [1:0]             gnt;
    logic [1:0]             rvalid;
    logic [DATA_W-1:0]      rdata;
    logic                   mem_en;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection: round-robin with a bounded burst for the
// port that won most recently.
module dmem_arb_pick
    import proc_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic [1:0]       req,
    input  logic             last,
    input  logic [CNT_W-1:0] cnt,
    output logic [1:0]       gnt
);

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                // cnt==0 means the previous cycle was idle, so the tie goes away from last
                if (cnt != '0 && cnt < BURST_LIM) gnt[last]  = 1'b1;
                else                              gnt[~last] = 1'b1;
            end
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core LSU (port 0) and the
// debug/loader port (port 1); drives the memory and returns load data.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = proc_pkg::DMEM_ADDR_W,
    parameter int unsigned DATA_W    = proc_pkg::DATA_W,
    parameter int unsigned MAX_BURST = 4
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    import proc_pkg::*;

    logic                      last_q, last_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      rd_pend_q, rd_pend_d;
    dmem_port_e                rd_port_q, rd_port_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d;

    logic [NUM_DMEM_PORTS-1:0] pick_gnt;
    logic [NUM_DMEM_PORTS-1:0] gnt_w;
    logic                      win_idx;
    logic                      ret_valid;
    dmem_req_t                 sel;

    dmem_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .req  (bus.req),
        .last (last_q),
        .cnt  (cnt_q),
        .gnt  (pick_gnt)
    );

    assign gnt_w   = rst ? '0 : pick_gnt;
    assign win_idx = gnt_w[1];
    assign bus.gnt = gnt_w;

    always_comb begin
        sel = '0;
        if (gnt_w != '0) begin
            sel.we    = bus.we[win_idx];
            sel.addr  = bus.addr[win_idx];
            sel.wdata = bus.wdata[win_idx];
        end
        bus.mem_en    = (gnt_w != '0);
        bus.mem_we    = sel.we;
        bus.mem_addr  = sel.addr;
        bus.mem_wdata = sel.wdata;
    end

    always_comb begin
        last_d    = last_q;
        cnt_d     = cnt_q;
        rd_pend_d = 1'b0;
        rd_port_d = rd_port_q;
        rdata_d   = rdata_q;

        if (gnt_w == '0) begin
            cnt_d = '0;
        end else if (win_idx == last_q) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end else begin
            last_d = win_idx;
            cnt_d  = CNT_W'(1);
        end

        if (gnt_w != '0 && !sel.we) begin
            rd_pend_d = 1'b1;
            rd_port_d = win_idx ? PORT_DBG : PORT_CORE;
        end

        // Memory data arrives one cycle after the access; a return cycle that
        // coincides with reset is suppressed.
        ret_valid  = rd_pend_q && !rst;
        bus.rvalid = '0;
        if (ret_valid) begin
            rdata_d    = bus.mem_rdata;
            bus.rvalid = (rd_port_q == PORT_DBG) ? 2'b10 : 2'b01;
        end
        bus.rdata = ret_valid ? bus.mem_rdata : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_port_q <= PORT_CORE;
            rdata_q   <= '0;
        end else begin
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic checked against a grant-history reference model.
module tb_dmem_arbiter;
    import proc_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Synchronous single-port memory with a back-door load path.
    logic [DW-1:0] ram [16];
    logic          bk_we;
    logic [3:0]    bk_addr;
    logic [DW-1:0] bk_data;

    always @(posedge clk) begin
        if (bk_we) ram[bk_addr] <= bk_data;
        else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[3:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr[3:0]];
        end
    end

    // Reference model: history of grants since the last idle cycle or reset.
    int            hist[$];
    int            last_port = 1;
    bit            m_rd_pend = 1'b0;
    int            m_rd_port = 0;
    logic [DW-1:0] m_rd_data = '0;
    logic [DW-1:0] m_rdata_hold = '0;
    logic [DW-1:0] model_mem [16];

    function automatic int model_pick(logic [1:0] r);
        int run;
        if (rst || r == 2'b00) return -1;
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == last_port; i--) run++;
        if (run > 0 && run < int'(MB)) return last_port;
        return 1 - last_port;
    endfunction

    always @(posedge clk) begin
        int g;
        g = model_pick(bus.req);
        if (bk_we) model_mem[bk_addr] = bk_data;
        if (rst) begin
            hist.delete();
            last_port    = 1;
            m_rd_pend    = 1'b0;
            m_rdata_hold = '0;
        end else begin
            if (m_rd_pend) m_rdata_hold = m_rd_data;
            m_rd_pend = 1'b0;
            if (g < 0) hist.delete();
            else begin
                hist.push_back(g);
                if (hist.size() > 32) void'(hist.pop_front());
                last_port = g;
                if (bus.we[g]) model_mem[bus.addr[g][3:0]] = bus.wdata[g];
                else begin
                    m_rd_pend = 1'b1;
                    m_rd_port = g;
                    m_rd_data = model_mem[bus.addr[g][3:0]];
                end
            end
        end
    end

    task automatic test_reset;
        bus.req = 2'b11;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
            checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); end
            checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
            checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", bus.rvalid); end
            checks++; if (bus.rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
            @(negedge clk);
        end
    endtask

    task automatic test_burst;
        logic [1:0] exp_seq [9];
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        rst = 1'b0;
        bus.req = 2'b11; bus.we = 2'b00;
        bus.addr[0] = AW'(1); bus.addr[1] = AW'(2);
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (bus.gnt !== exp_seq[i]) begin
                errors++; $display("FAIL burst_gnt[%0d]: got %b want %b", i, bus.gnt, exp_seq[i]);
            end
            @(negedge clk);
        end
        bus.req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_single_load;
        bus.req = 2'b01; bus.we = 2'b00; bus.addr[0] = AW'(5);
        #1;
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL load_gnt: got %b want 01", bus.gnt); end
        checks++; if (bus.mem_addr !== AW'(5)) begin errors++; $display("FAIL load_mem_addr: got %0d want 5", bus.mem_addr); end
        @(negedge clk);
        bus.req = 2'b00;
        #1;
        checks++; if (bus.rvalid !== 2'b01) begin errors++; $display("FAIL load_rvalid: got %b want 01", bus.rvalid); end
        checks++; if (bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", bus.rdata); end
        @(negedge clk);
    endtask

    task automatic test_release;
        bus.req = 2'b10; bus.we = 2'b10; bus.addr[1] = AW'(7); bus.wdata[1] = 32'h12345678;
        #1;
        checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL wr_gnt: got %b want 10", bus.gnt); end
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we: got %b want 1", bus.mem_we); end
        checks++; if (bus.mem_addr !== AW'(7)) begin errors++; $display("FAIL wr_mem_addr: got %0d want 7", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_mem_wdata: got %h want 12345678", bus.mem_wdata); end
        @(negedge clk);
        bus.req = 2'b01; bus.we = 2'b00; bus.addr[0] = AW'(7);
        #1;
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rd7_gnt: got %b want 01", bus.gnt); end
        @(negedge clk);
        bus.req = 2'b00;
        #1;
        checks++; if (bus.rvalid !== 2'b01) begin errors++; $display("FAIL rd7_rvalid: got %b want 01", bus.rvalid); end
        checks++; if (bus.rdata !== 32'h12345678) begin errors++; $display("FAIL rd7_rdata: got %h want 12345678", bus.rdata); end
        @(negedge clk);
    endtask

    task automatic test_idle_burst;
        bus.req = 2'b01; bus.we = 2'b00; bus.addr[0] = AW'(2); bus.addr[1] = AW'(3);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL idle_pre_gnt[%0d]: got %b want 01", i, bus.gnt); end
            @(negedge clk);
        end
        bus.req = 2'b00;
        #1;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL idle_mem_en: got %b want 0", bus.mem_en); end
        @(negedge clk);
        bus.req = 2'b11;
        #1;
        checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL idle_tie_gnt: got %b want 10", bus.gnt); end
        @(negedge clk);
        bus.req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read;
        bus.req = 2'b10; bus.we = 2'b00; bus.addr[1] = AW'(3);
        #1;
        checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL midrd_gnt: got %b want 10", bus.gnt); end
        @(negedge clk);
        rst = 1'b1; bus.req = 2'b00;
        #1;
        checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("FAIL midrd_rvalid: got %b want 00", bus.rvalid); end
        @(negedge clk);
        rst = 1'b0; bus.req = 2'b11;
        #1;
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL midrd_tie_gnt: got %b want 01", bus.gnt); end
        @(negedge clk);
        bus.req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_random;
        bit [1:0]      pend;
        int            g;
        logic [1:0]    e_gnt, e_rv;
        logic          e_en, e_we, ret;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rd;
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    pend[p]       = 1'b1;
                    bus.we[p]     = 1'($urandom_range(0, 1));
                    bus.addr[p]   = AW'($urandom_range(0, 15));
                    bus.wdata[p]  = $urandom;
                end else if (pend[p] && $urandom_range(0, 9) == 0) begin
                    pend[p] = 1'b0;
                end
            end
            bus.req = pend;
            #1;
            g      = model_pick(bus.req);
            e_gnt  = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
            e_en   = (g >= 0);
            e_we   = (g >= 0) ? bus.we[g] : 1'b0;
            e_addr = (g >= 0) ? bus.addr[g] : '0;
            e_wd   = (g >= 0) ? bus.wdata[g] : '0;
            ret    = m_rd_pend && !rst;
            e_rv   = !ret ? 2'b00 : ((m_rd_port == 0) ? 2'b01 : 2'b10);
            e_rd   = ret ? m_rd_data : m_rdata_hold;
            checks++; if (bus.gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt @%0d: got %b want %b", n, bus.gnt, e_gnt); end
            checks++; if (bus.mem_en !== e_en) begin errors++; $display("FAIL rnd_mem_en @%0d: got %b want %b", n, bus.mem_en, e_en); end
            checks++; if (bus.mem_we !== e_we) begin errors++; $display("FAIL rnd_mem_we @%0d: got %b want %b", n, bus.mem_we, e_we); end
            checks++; if (bus.mem_addr !== e_addr) begin errors++; $display("FAIL rnd_mem_addr @%0d: got %0d want %0d", n, bus.mem_addr, e_addr); end
            checks++; if (bus.mem_wdata !== e_wd) begin errors++; $display("FAIL rnd_mem_wdata @%0d: got %h want %h", n, bus.mem_wdata, e_wd); end
            checks++; if (bus.rvalid !== e_rv) begin errors++; $display("FAIL rnd_rvalid @%0d: got %b want %b", n, bus.rvalid, e_rv); end
            checks++; if (bus.rdata !== e_rd) begin errors++; $display("FAIL rnd_rdata @%0d: got %h want %h", n, bus.rdata, e_rd); end
            @(negedge clk);
            if (g >= 0) pend[g] = 1'b0;
        end
        rst = 1'b0;
        bus.req = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
        bk_we = 1'b0; bk_addr = '0; bk_data = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bk_we   = 1'b1;
            bk_addr = 4'(i);
            bk_data = (i == 5) ? 32'hDEADBEEF : $urandom;
        end
        @(negedge clk);
        bk_we = 1'b0;

        test_reset;
        test_burst;
        test_single_load;
        test_release;
        test_idle_burst;
        test_reset_mid_read;
        test_random;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the processor's single-port data memory between the core load/store path (port 0) and the debug/loader port (port 1), which preloads and dumps data memory. Arbitration is round-robin with a bounded burst: a winning port keeps the grant for up to `MAX_BURST` consecutive accesses while the other port waits. It sits between the core LSU, the debug port and `data_mem`, and drives the memory's enable, write-enable, address and write data.

## Interface
- `ADDR_W`, 10: word-address width into data memory.
- `DATA_W`, 32: data width.
- `MAX_BURST`, 4: maximum consecutive grants to one port while the other requests; legal range 1..15.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in [1:0]: access request per port; held until granted.
- `we` in [1:0]: per-port write enable; 1 = store, 0 = load.
- `addr` in [1:0][ADDR_W-1:0]: per-port word address.
- `wdata` in [1:0][DATA_W-1:0]: per-port store data.
- `gnt` out [1:0]: one-hot or zero; combinational grant for this cycle.
- `rvalid` out [1:0]: registered; load data valid for a port.
- `rdata` out [DATA_W-1:0]: registered load data, shared by both ports.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 1: memory write this cycle.
- `mem_addr` out [ADDR_W-1:0]: memory address.
- `mem_wdata` out [DATA_W-1:0]: memory write data.
- `mem_rdata` in [DATA_W-1:0]: memory read data, valid one cycle after a read access.

## Operation
- State: `last` (1 bit, port granted most recently), `cnt` (4 bits, consecutive grants to `last`), `rd_port` and `rd_pend` (pending read return).
- Winner selection each cycle, when `rst`=0:
  - No request: no grant, `mem_en`=0.
  - Exactly one request: grant that port.
  - Both requesting: if `cnt`≠0 and `cnt`<`MAX_BURST`, grant `last`; otherwise grant `~last`.
- On a grant to port w, the memory signals are driven from port w in the same cycle: `mem_en`=1, `mem_we`=`we[w]`, `mem_addr`=`addr[w]`, `mem_wdata`=`wdata[w]`.
- When no port is granted, `mem_we`=0, and `mem_addr`/`mem_wdata` are 0.
- Counter update at the clock edge:
  - Grant to w with w==`last`: `cnt` increments, saturating at 15.
  - Grant to w with w≠`last`: `last`=w, `cnt`=1.
  - Cycle with no grant: `cnt`=0, `last` unchanged.
- Read return: a granted load sets `rd_pend`=1 and `rd_port`=w. In the next cycle, `rvalid[rd_port]`=1 and `rdata`=`mem_rdata`.
- Writes produce no `rvalid`; `gnt` is the write acknowledge.
- `rdata` holds its last value when `rvalid`=0.
- Requesters must hold `we`, `addr` and `wdata` stable while `req`=1 and `gnt`=0. A requester may drop `req` before being granted, and no access occurs.

## Timing
- Reset values: `last`=1 (so port 0 wins the first tie), `cnt`=0, `rvalid`=2'b00, `rdata`=0, `rd_pend`=0.
- While `rst`=1: `gnt`=0, `mem_en`=0, `mem_we`=0.
- Grant latency: 0 cycles (same cycle as `req`) when the port wins.
- Load latency: `rvalid` is asserted 1 cycle after `gnt`.
- Throughput: one access per cycle. Back-to-back loads from alternating ports give alternating `rvalid` bits on consecutive cycles.
- Starvation bound: a continuously requesting port waits at most `MAX_BURST` cycles.
- Reset mid-operation: a load granted in the cycle before `rst` rises returns no `rvalid`. Its return cycle coincides with reset, so the registered outputs are cleared.
- A new grant in the same cycle as an `rvalid` is legal. The pipeline overlaps.

## Structure
- Shared package `proc_pkg`:
  - `DATA_W` constant.
  - `NUM_DMEM_PORTS`=2.
  - `dmem_port_e` enum with `PORT_CORE`=0 and `PORT_DBG`=1.
  - A `dmem_req_t` struct (`we`, `addr`, `wdata`).
- One natural sub-module: `dmem_arb_pick`. It is combinational and takes `req`, `last`, `cnt` and `MAX_BURST`, and returns the one-hot `gnt`.
- Everything else (counter, `last` register, read-return register, memory mux) lives in `dmem_arbiter`.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `req`=2'b11. Expect `gnt`=0, `mem_en`=0, `rvalid`=0, `rdata`=0.
- Single load: port 0 requests a load at `addr`=5, with memory word 5 = 0xDEADBEEF. Expect `gnt`=2'b01 in the same cycle, then the next cycle `rvalid`=2'b01 and `rdata`=0xDEADBEEF.
- Burst limit (`MAX_BURST`=4): both ports request continuously from reset. Expect `gnt` sequence 01,01,01,01,10,10,10,10,01…
- Release: port 1 writes 0x12345678 to `addr`=7, then port 0 loads `addr`=7. Expect `mem_we`=1 with `mem_wdata`=0x12345678 in the first cycle, then port 0 `rvalid` with `rdata`=0x12345678.
- Idle resets burst: port 0 is granted twice, there is 1 idle cycle, then both request. Expect `gnt`=2'b10 (cnt=0, so `~last` wins).
- Reset mid-read: port 1 load is granted and `rst` is asserted the next cycle. Expect `rvalid`=0 in that cycle and `last`=1 afterwards (port 0 wins the first tie).
